// File: rtl/gp_defs.sv
// Shared definitions for the 8-bit datapath and its controller:
// opcodes, controller state encodings and A-source select codes.
package gp_defs;

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_STORE = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_INPUT = 3'b100;
    localparam logic [2:0] OP_JZ    = 3'b101;
    localparam logic [2:0] OP_JPOS  = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    typedef enum logic [3:0] {
        S_START  = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_LOAD   = 4'd3,
        S_STORE  = 4'd4,
        S_ADD    = 4'd5,
        S_SUB    = 4'd6,
        S_INWAIT = 4'd7,
        S_INLOAD = 4'd8,
        S_JZ     = 4'd9,
        S_JPOS   = 4'd10,
        S_HALT   = 4'd11
    } state_t;

    // Code 2'b11 is reserved and never driven.
    localparam logic [1:0] ASEL_ALU = 2'b00;
    localparam logic [1:0] ASEL_IN  = 2'b01;
    localparam logic [1:0] ASEL_RAM = 2'b10;

endpackage

// File: rtl/enter_sync.sv
// Brings the raw Enter pushbutton into the Clock domain and turns each
// press into a single-cycle pulse, however long the button is held.
module enter_sync (
    input  logic Clock,
    input  logic Reset,
    input  logic Enter,
    output logic enter_pulse
);

    logic sync1;
    logic sync2;
    logic prev;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= Enter;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign enter_pulse = sync2 & ~prev;

endmodule

// File: rtl/control_unit.sv
// Fetch/decode/execute sequencer for the 8-bit datapath. Outputs are decoded
// from the state register; only PCload in JZ/JPOS also looks at a flag.
module control_unit
    import gp_defs::*;
(
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Enter,
    input  logic [2:0] IR,
    input  logic       Aeq0,
    input  logic       Apos,
    output logic       PCload,
    output logic       JMPmux,
    output logic       IRload,
    output logic       Meminst,
    output logic       MemWr,
    output logic       Aload,
    output logic       Sub,
    output logic [1:0] Asel,
    output logic       Halt,
    output logic [3:0] State
);

    state_t state_q;
    state_t state_d;
    logic   run_q;
    logic   enter_pulse;

    enter_sync u_enter_sync (
        .Clock       (Clock),
        .Reset       (Reset),
        .Enter       (Enter),
        .enter_pulse (enter_pulse)
    );

    // run_q holds START for one full cycle after reset release, so the
    // first FETCH lands on the second rising edge.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_START;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_START:  if (run_q) state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (IR)
                    OP_LOAD:  state_d = S_LOAD;
                    OP_STORE: state_d = S_STORE;
                    OP_ADD:   state_d = S_ADD;
                    OP_SUB:   state_d = S_SUB;
                    OP_INPUT: state_d = S_INWAIT;
                    OP_JZ:    state_d = S_JZ;
                    OP_JPOS:  state_d = S_JPOS;
                    default:  state_d = S_HALT;
                endcase
            end
            S_LOAD, S_STORE, S_ADD, S_SUB,
            S_INLOAD, S_JZ, S_JPOS: state_d = S_FETCH;
            // Pulses seen in any other state are simply dropped.
            S_INWAIT: if (enter_pulse) state_d = S_INLOAD;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_START;
        endcase
    end

    always_comb begin
        PCload  = 1'b0;
        JMPmux  = 1'b0;
        IRload  = 1'b0;
        Meminst = 1'b0;
        MemWr   = 1'b0;
        Aload   = 1'b0;
        Sub     = 1'b0;
        Asel    = ASEL_ALU;
        Halt    = 1'b0;
        case (state_q)
            S_FETCH: begin
                Meminst = 1'b1;
                IRload  = 1'b1;
                PCload  = 1'b1;
            end
            S_LOAD: begin
                Asel  = ASEL_RAM;
                Aload = 1'b1;
            end
            S_STORE:  MemWr = 1'b1;
            S_ADD:    Aload = 1'b1;
            S_SUB: begin
                Aload = 1'b1;
                Sub   = 1'b1;
            end
            S_INWAIT: Asel = ASEL_IN;
            S_INLOAD: begin
                Asel  = ASEL_IN;
                Aload = 1'b1;
            end
            S_JZ: begin
                JMPmux = 1'b1;
                PCload = Aeq0;
            end
            S_JPOS: begin
                JMPmux = 1'b1;
                PCload = Apos;
            end
            S_HALT:   Halt = 1'b1;
            default:  ;
        endcase
    end

    assign State = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: walks every instruction through
// fetch/decode/execute and checks the full output vector each cycle.
module tb_control_unit;

    logic       Clock;
    logic       Reset;
    logic       Enter;
    logic [2:0] IR;
    logic       Aeq0;
    logic       Apos;
    logic       PCload, JMPmux, IRload, Meminst, MemWr, Aload, Sub, Halt;
    logic [1:0] Asel;
    logic [3:0] State;

    int checks = 0;
    int errors = 0;

    // {PCload,JMPmux,IRload,Meminst,MemWr,Aload,Sub,Asel[1:0],Halt,State[3:0]}
    logic [13:0] obs;
    assign obs = {PCload, JMPmux, IRload, Meminst, MemWr, Aload, Sub, Asel, Halt, State};

    control_unit dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .Enter   (Enter),
        .IR      (IR),
        .Aeq0    (Aeq0),
        .Apos    (Apos),
        .PCload  (PCload),
        .JMPmux  (JMPmux),
        .IRload  (IRload),
        .Meminst (Meminst),
        .MemWr   (MemWr),
        .Aload   (Aload),
        .Sub     (Sub),
        .Asel    (Asel),
        .Halt    (Halt),
        .State   (State)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic logic [13:0] ev(input logic pcl, input logic jmp, input logic irl,
                                       input logic mi, input logic mw, input logic al,
                                       input logic sb, input logic [1:0] as, input logic h,
                                       input logic [3:0] st);
        return {pcl, jmp, irl, mi, mw, al, sb, as, h, st};
    endfunction

    function automatic logic [13:0] v_fetch();
        return ev(1, 0, 1, 1, 0, 0, 0, 2'b00, 0, 4'd1);
    endfunction

    function automatic logic [13:0] v_decode();
        return ev(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 4'd2);
    endfunction

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    // Reset, release, and land in the first FETCH (second edge after release).
    task automatic go_fetch();
        Reset = 1'b0;
        #7;
        @(negedge Clock);
        Reset = 1'b1;
        step();
        step();
    endtask

    task automatic test_reset();
        logic [13:0] exp_seq[3];
        exp_seq[0] = ev(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 4'd0);
        exp_seq[1] = v_fetch();
        exp_seq[2] = v_decode();
        IR = 3'b000;
        go_fetch();
        checks++;
        if (obs !== v_fetch()) begin
            errors++;
            $display("FAIL first_fetch: got %h want %h", obs, v_fetch());
        end
        // Assert reset between edges: outputs must clear with no clock edge.
        #2;
        Reset = 1'b0;
        #1;
        checks++;
        if (obs !== 14'h0) begin
            errors++;
            $display("FAIL async_reset: got %h want %h", obs, 14'h0);
        end
        @(negedge Clock);
        Reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (obs !== exp_seq[i]) begin
                errors++;
                $display("FAIL reset_release_%0d: got %h want %h", i, obs, exp_seq[i]);
            end
        end
    endtask

    // Entered in DECODE of a LOAD; then STORE, ADD, SUB in turn.
    task automatic test_alu_mem();
        logic [2:0]  ops[4];
        logic [13:0] exec_v[4];
        ops[0] = 3'b000; exec_v[0] = ev(0, 0, 0, 0, 0, 1, 0, 2'b10, 0, 4'd3);
        ops[1] = 3'b001; exec_v[1] = ev(0, 0, 0, 0, 1, 0, 0, 2'b00, 0, 4'd4);
        ops[2] = 3'b010; exec_v[2] = ev(0, 0, 0, 0, 0, 1, 0, 2'b00, 0, 4'd5);
        ops[3] = 3'b011; exec_v[3] = ev(0, 0, 0, 0, 0, 1, 1, 2'b00, 0, 4'd6);
        for (int i = 0; i < 4; i++) begin
            IR = ops[i];
            if (i != 0) begin
                step();
                checks++;
                if (obs !== v_decode()) begin
                    errors++;
                    $display("FAIL decode_op%0d: got %h want %h", ops[i], obs, v_decode());
                end
            end
            step();
            checks++;
            if (obs !== exec_v[i]) begin
                errors++;
                $display("FAIL exec_op%0d: got %h want %h", ops[i], obs, exec_v[i]);
            end
            step();
            checks++;
            if (obs !== v_fetch()) begin
                errors++;
                $display("FAIL refetch_op%0d: got %h want %h", ops[i], obs, v_fetch());
            end
        end
    endtask

    // Entered in FETCH.
    task automatic test_input();
        logic [13:0] v_wait;
        logic [13:0] v_inload;
        int          bad;
        v_wait   = ev(0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 4'd7);
        v_inload = ev(0, 0, 0, 0, 0, 1, 0, 2'b01, 0, 4'd8);
        IR = 3'b100;
        Enter = 1'b0;
        step();
        step();
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (obs !== v_wait) bad++;
            step();
        end
        checks++;
        if (bad != 0 || obs !== v_wait) begin
            errors++;
            $display("FAIL inwait_idle: got %h want %h (bad cycles %0d)", obs, v_wait, bad);
        end
        Enter = 1'b1;
        step();
        step();
        checks++;
        if (obs !== v_wait) begin
            errors++;
            $display("FAIL inwait_sync_delay: got %h want %h", obs, v_wait);
        end
        step();
        checks++;
        if (obs !== v_inload) begin
            errors++;
            $display("FAIL inload: got %h want %h", obs, v_inload);
        end
        step();
        checks++;
        if (obs !== v_fetch()) begin
            errors++;
            $display("FAIL input_refetch: got %h want %h", obs, v_fetch());
        end
        // Button still held: the next INPUT must wait for a fresh press.
        step();
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (obs !== v_wait) begin
            errors++;
            $display("FAIL held_single_pulse: got %h want %h", obs, v_wait);
        end
        Enter = 1'b0;
        step();
        step();
        step();
        Enter = 1'b1;
        step();
        step();
        step();
        checks++;
        if (obs !== v_inload) begin
            errors++;
            $display("FAIL second_press: got %h want %h", obs, v_inload);
        end
        Enter = 1'b0;
        step();
        checks++;
        if (obs !== v_fetch()) begin
            errors++;
            $display("FAIL second_refetch: got %h want %h", obs, v_fetch());
        end
    endtask

    // Entered in FETCH.
    task automatic test_jumps();
        logic [2:0]  ops[4];
        logic        flag[4];
        logic [13:0] exp_v[4];
        ops[0] = 3'b101; flag[0] = 1'b1; exp_v[0] = ev(1, 1, 0, 0, 0, 0, 0, 2'b00, 0, 4'd9);
        ops[1] = 3'b101; flag[1] = 1'b0; exp_v[1] = ev(0, 1, 0, 0, 0, 0, 0, 2'b00, 0, 4'd9);
        ops[2] = 3'b110; flag[2] = 1'b0; exp_v[2] = ev(0, 1, 0, 0, 0, 0, 0, 2'b00, 0, 4'd10);
        ops[3] = 3'b110; flag[3] = 1'b1; exp_v[3] = ev(1, 1, 0, 0, 0, 0, 0, 2'b00, 0, 4'd10);
        for (int i = 0; i < 4; i++) begin
            IR = ops[i];
            // Drive the flag under test and the opposite value on the other flag.
            if (ops[i] == 3'b101) begin
                Aeq0 = flag[i];
                Apos = ~flag[i];
            end else begin
                Apos = flag[i];
                Aeq0 = ~flag[i];
            end
            step();
            step();
            checks++;
            if (obs !== exp_v[i]) begin
                errors++;
                $display("FAIL jump_%0d: got %h want %h", i, obs, exp_v[i]);
            end
            step();
            checks++;
            if (obs !== v_fetch()) begin
                errors++;
                $display("FAIL jump_refetch_%0d: got %h want %h", i, obs, v_fetch());
            end
        end
    endtask

    // Entered in FETCH.
    task automatic test_halt();
        logic [13:0] v_halt;
        int          bad;
        v_halt = ev(0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 4'd11);
        IR = 3'b111;
        step();
        step();
        checks++;
        if (obs !== v_halt) begin
            errors++;
            $display("FAIL halt_entry: got %h want %h", obs, v_halt);
        end
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            Enter = ~Enter;
            IR = 3'($urandom_range(0, 7));
            step();
            if (obs !== v_halt) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL halt_hold: got %0d bad cycles want 0", bad);
        end
        #2;
        Reset = 1'b0;
        #1;
        checks++;
        if (obs !== 14'h0) begin
            errors++;
            $display("FAIL halt_reset: got %h want %h", obs, 14'h0);
        end
        Enter = 1'b0;
    endtask

    initial begin
        Reset = 1'b0;
        Enter = 1'b0;
        IR    = 3'b000;
        Aeq0  = 1'b0;
        Apos  = 1'b0;
        #3;
        checks++;
        if (obs !== 14'h0) begin
            errors++;
            $display("FAIL reset_state: got %h want %h", obs, 14'h0);
        end
        test_reset();
        test_alu_mem();
        test_input();
        test_jumps();
        test_halt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
